// File: rtl/risc16b_mem_pkg.sv
// risc16b_mem_pkg: shared definitions for the risc16b memory/MMIO subsystem.
//   - MMIO word offsets (d_addr[7:1]) inside the MMIO page
//   - bit positions of the TX status word
//   - mmio_sel_t: decoded target of a data-port access
//   - mmio_decode(): page hit + word offset -> mmio_sel_t
//   - sat_inc16(): saturating 16-bit increment used by the optional stats counters
package risc16b_mem_pkg;

    localparam logic [6:0] OFF_LED    = 7'h00;
    localparam logic [6:0] OFF_TX     = 7'h01;
    localparam logic [6:0] OFF_CNTLO  = 7'h02;
    localparam logic [6:0] OFF_CNTHI  = 7'h03;
    localparam logic [6:0] OFF_HALT   = 7'h04;
    localparam logic [6:0] OFF_STAT_I = 7'h05;
    localparam logic [6:0] OFF_STAT_R = 7'h06;
    localparam logic [6:0] OFF_STAT_W = 7'h07;

    localparam int unsigned ST_EMPTY = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_OVF   = 2;

    typedef enum logic [3:0] {
        SEL_RAM,
        SEL_LED,
        SEL_TX,
        SEL_CNTLO,
        SEL_CNTHI,
        SEL_HALT,
        SEL_STAT_I,
        SEL_STAT_R,
        SEL_STAT_W,
        SEL_NONE
    } mmio_sel_t;

    function automatic mmio_sel_t mmio_decode(input logic page_hit, input logic [6:0] off);
        mmio_sel_t sel;
        sel = SEL_NONE;
        if (!page_hit) begin
            sel = SEL_RAM;
        end else begin
            case (off)
                OFF_LED:    sel = SEL_LED;
                OFF_TX:     sel = SEL_TX;
                OFF_CNTLO:  sel = SEL_CNTLO;
                OFF_CNTHI:  sel = SEL_CNTHI;
                OFF_HALT:   sel = SEL_HALT;
                OFF_STAT_I: sel = SEL_STAT_I;
                OFF_STAT_R: sel = SEL_STAT_R;
                OFF_STAT_W: sel = SEL_STAT_W;
                default:    sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/risc16b_tx_fifo.sv
// risc16b_tx_fifo: byte FIFO behind the TX MMIO register.
//   clk, rst : clock, synchronous active-high reset (empties FIFO, clears ovf)
//   push/din : enqueue din; accepted when not full, or when full and popping the same cycle
//   pop      : dequeue head; ignored when empty
//   dout     : head byte (0 while empty, no fall-through of a same-cycle push)
//   full, empty, ovf : status; ovf is sticky, set by a push dropped on a full FIFO
module risc16b_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic       ovf
);
    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign ovf   = ovf_q;

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        ovf_d    = ovf_q | (push && !do_push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/risc16b_mem_sys.sv
// risc16b_mem_sys: unified byte-addressed RAM plus one MMIO page for risc16b.
//   clk, rst             : clock, synchronous active-high reset
//   i_addr, i_oe, i_din  : instruction read port (combinational word read)
//   d_addr, d_oe, d_din  : data read port (combinational)
//   d_dout, d_we         : data write; d_we[0] -> bits[15:8], d_we[1] -> bits[7:0]
//   led                  : LED register (MMIO word 0)
//   tx_data/valid/ready  : TX FIFO output handshake (MMIO word 1 pushes)
//   halt                 : sticky, set by writing MMIO word 4
//   i_fault              : sticky, set by an instruction fetch from the MMIO page
// Optional feature macro MEM_STATS_EN: saturating fetch/read/write counters at
// MMIO words 5..7; without it those words read 0 and writes are ignored.
module risc16b_mem_sys
    import risc16b_mem_pkg::*;
#(
    parameter int unsigned RAM_AW     = 16,
    parameter logic [7:0]  MMIO_PAGE  = 8'h7f,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_addr,
    input  logic        i_oe,
    output logic [15:0] i_din,
    input  logic [15:0] d_addr,
    input  logic        d_oe,
    input  logic [15:0] d_dout,
    input  logic [1:0]  d_we,
    output logic [15:0] d_din,
    output logic [15:0] led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic        i_fault
);
    logic [7:0] ram_q [2**RAM_AW];

    logic              i_page, d_page, d_wr;
    logic [RAM_AW-1:0] i_even, i_odd, d_even, d_odd;
    logic [1:0]        ram_we;
    mmio_sel_t         sel;

    // Word accesses ignore addr[0]; bit 0 of each address is deliberately unused.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = i_addr[0] ^ d_addr[0];

    assign i_page = (i_addr[15:8] == MMIO_PAGE);
    assign d_page = (d_addr[15:8] == MMIO_PAGE);
    assign i_even = {i_addr[RAM_AW-1:1], 1'b0};
    assign i_odd  = {i_addr[RAM_AW-1:1], 1'b1};
    assign d_even = {d_addr[RAM_AW-1:1], 1'b0};
    assign d_odd  = {d_addr[RAM_AW-1:1], 1'b1};
    assign d_wr   = |d_we;
    assign sel    = mmio_decode(d_page, d_addr[7:1]);
    assign ram_we = (sel == SEL_RAM) ? d_we : 2'b00;

    assign i_din = (i_oe && !i_page) ? {ram_q[i_even], ram_q[i_odd]} : '0;

    always_ff @(posedge clk) begin
        if (ram_we[0]) ram_q[d_even] <= d_dout[15:8];
        if (ram_we[1]) ram_q[d_odd]  <= d_dout[7:0];
    end

    // TX FIFO
    logic tx_empty, tx_full, tx_ovf, tx_push;

    assign tx_push  = (sel == SEL_TX) && d_wr;
    assign tx_valid = !tx_empty;

    risc16b_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (d_dout[7:0]),
        .pop   (tx_valid && tx_ready),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .ovf   (tx_ovf)
    );

    // MMIO registers
    logic [15:0] led_q, led_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] shadow_q, shadow_d;
    logic        halt_q, halt_d;
    logic        i_fault_q, i_fault_d;

    always_comb begin
        led_d = led_q;
        if (sel == SEL_LED) begin
            if (d_we[0]) led_d[15:8] = d_dout[15:8];
            if (d_we[1]) led_d[7:0]  = d_dout[7:0];
        end
        cnt_d     = ((sel == SEL_CNTLO) && d_wr) ? '0 : cnt_q + 32'd1;
        // Reading the low half snapshots the high half so a LO/HI read pair is coherent.
        shadow_d  = ((sel == SEL_CNTLO) && d_oe) ? cnt_q[31:16] : shadow_q;
        halt_d    = halt_q | ((sel == SEL_HALT) && d_wr);
        i_fault_d = i_fault_q | (i_oe && i_page);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            halt_q    <= 1'b0;
            i_fault_q <= 1'b0;
        end else begin
            led_q     <= led_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            halt_q    <= halt_d;
            i_fault_q <= i_fault_d;
        end
    end

    assign led     = led_q;
    assign halt    = halt_q;
    assign i_fault = i_fault_q;

`ifdef MEM_STATS_EN
    logic [15:0] st_if_q, st_if_d;
    logic [15:0] st_rd_q, st_rd_d;
    logic [15:0] st_wr_q, st_wr_d;
    logic        st_clr;

    // A clearing write is not itself counted.
    always_comb begin
        st_clr  = (sel == SEL_STAT_I) && d_wr;
        st_if_d = st_clr ? '0 : sat_inc16(st_if_q, i_oe);
        st_rd_d = st_clr ? '0 : sat_inc16(st_rd_q, d_oe);
        st_wr_d = st_clr ? '0 : sat_inc16(st_wr_q, d_wr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_if_q <= '0;
            st_rd_q <= '0;
            st_wr_q <= '0;
        end else begin
            st_if_q <= st_if_d;
            st_rd_q <= st_rd_d;
            st_wr_q <= st_wr_d;
        end
    end
`endif

    // Data read mux
    logic [15:0] rd_mmio;

    always_comb begin
        rd_mmio = '0;
        case (sel)
            SEL_LED: rd_mmio = led_q;
            SEL_TX: begin
                rd_mmio[ST_EMPTY] = tx_empty;
                rd_mmio[ST_FULL]  = tx_full;
                rd_mmio[ST_OVF]   = tx_ovf;
            end
            SEL_CNTLO: rd_mmio = cnt_q[15:0];
            SEL_CNTHI: rd_mmio = shadow_q;
`ifdef MEM_STATS_EN
            SEL_STAT_I: rd_mmio = st_if_q;
            SEL_STAT_R: rd_mmio = st_rd_q;
            SEL_STAT_W: rd_mmio = st_wr_q;
`endif
            default: rd_mmio = '0;
        endcase
    end

    always_comb begin
        d_din = '0;
        if (d_oe) begin
            d_din = (sel == SEL_RAM) ? {ram_q[d_even], ram_q[d_odd]} : rd_mmio;
        end
    end

endmodule

// File: tb/tb_risc16b_mem_sys.sv
module tb_risc16b_mem_sys;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_addr = '0;
    logic        i_oe = 1'b0;
    logic [15:0] i_din;
    logic [15:0] d_addr = '0;
    logic        d_oe = 1'b0;
    logic [15:0] d_dout = '0;
    logic [1:0]  d_we = '0;
    logic [15:0] d_din;
    logic [15:0] led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        halt;
    logic        i_fault;

    always #5 clk = ~clk;

    risc16b_mem_sys #(
        .RAM_AW     (16),
        .MMIO_PAGE  (8'h7f),
        .FIFO_DEPTH (DEPTH),
        .INIT_FILE  ("")
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_addr   (i_addr),
        .i_oe     (i_oe),
        .i_din    (i_din),
        .d_addr   (d_addr),
        .d_oe     (d_oe),
        .d_dout   (d_dout),
        .d_we     (d_we),
        .d_din    (d_din),
        .led      (led),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .halt     (halt),
        .i_fault  (i_fault)
    );

    // Expected outputs for one cycle, pushed by the driver, popped by the monitor.
    typedef struct {
        logic [15:0] d_exp;
        logic [15:0] i_exp;
        logic        txv;
        logic [15:0] led;
        logic        halt;
        logic        ifault;
        logic        txd0;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  tx_sb[$];
    int unsigned total = 0;
    int unsigned bad = 0;

    // Reference model state
    logic [7:0]  mem_m [int];
    logic [15:0] led_m;
    logic        halt_m, ifault_m, ovf_m, after_rst_m;
    logic [31:0] cnt_m;
    logic [15:0] shadow_m;
    logic [7:0]  fifo_m[$];
    logic [15:0] st_m [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] ram_word(input logic [15:0] a);
        int e;
        e = int'(a & 16'hFFFE);
        return {mem_m[e], mem_m[e + 1]};
    endfunction

    function automatic logic [15:0] model_fetch(input logic ioe, input logic [15:0] ia);
        if (!ioe || ia[15:8] == 8'h7f) return 16'h0000;
        return ram_word(ia);
    endfunction

    function automatic logic [15:0] model_read(input logic doe, input logic [15:0] da);
        if (!doe) return 16'h0000;
        if (da[15:8] != 8'h7f) return ram_word(da);
        case (da[7:1])
            7'd0: return led_m;
            7'd1: return {13'b0, ovf_m, fifo_m.size() == DEPTH, fifo_m.size() == 0};
            7'd2: return cnt_m[15:0];
            7'd3: return shadow_m;
`ifdef MEM_STATS_EN
            7'd5: return st_m[0];
            7'd6: return st_m[1];
            7'd7: return st_m[2];
`endif
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        led_m = '0; halt_m = 0; ifault_m = 0; ovf_m = 0; cnt_m = '0; shadow_m = '0;
        fifo_m.delete(); tx_sb.delete();
        for (int k = 0; k < 3; k++) st_m[k] = '0;
        after_rst_m = 1;
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v, input logic en);
        return (en && v < 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    // Apply the architectural effect of one clock edge with the given inputs.
    task automatic model_edge(input logic r, input logic ioe, input logic [15:0] ia, input logic doe,
                              input logic [15:0] da, input logic [15:0] dd, input logic [1:0] we,
                              input logic rdy);
        logic       mmio;
        logic [6:0] off;
        logic       was_full, pop;
        logic [31:0] cnt_next;
        mmio = (da[15:8] == 8'h7f);
        off  = da[7:1];
        if (r) begin
            model_reset();
            return;
        end
        after_rst_m = 0;
        cnt_next = cnt_m + 1;
        if (mmio) begin
            if (off == 0) begin
                if (we[0]) led_m[15:8] = dd[15:8];
                if (we[1]) led_m[7:0]  = dd[7:0];
            end
            if (off == 2 && we != 0) cnt_next = 0;
            if (off == 2 && doe) shadow_m = cnt_m[31:16];
            if (off == 4 && we != 0) halt_m = 1;
        end else begin
            if (we[0]) mem_m[int'(da & 16'hFFFE)] = dd[15:8];
            if (we[1]) mem_m[int'(da | 16'h0001)] = dd[7:0];
        end
        was_full = (fifo_m.size() == DEPTH);
        pop = rdy && fifo_m.size() != 0;
        if (pop) fifo_m.delete(0);
        if (mmio && off == 1 && we != 0) begin
            if (!was_full || pop) begin
                fifo_m.push_back(dd[7:0]);
                tx_sb.push_back(dd[7:0]);
            end else begin
                ovf_m = 1;
            end
        end
        if (ioe && ia[15:8] == 8'h7f) ifault_m = 1;
        if (mmio && off == 5 && we != 0) begin
            for (int k = 0; k < 3; k++) st_m[k] = '0;
        end else begin
            st_m[0] = sat(st_m[0], ioe);
            st_m[1] = sat(st_m[1], doe);
            st_m[2] = sat(st_m[2], we != 0);
        end
        cnt_m = cnt_next;
    endtask

    // Driver: called just after a posedge; one call = one clock cycle.
    task automatic op(input logic r, input logic ioe, input logic [15:0] ia, input logic doe,
                      input logic [15:0] da, input logic [15:0] dd, input logic [1:0] we,
                      input logic rdy);
        exp_t e;
        rst = r; i_oe = ioe; i_addr = ia; d_oe = doe; d_addr = da; d_dout = dd; d_we = we;
        tx_ready = rdy;
        e.d_exp  = model_read(doe, da);
        e.i_exp  = model_fetch(ioe, ia);
        e.txv    = fifo_m.size() != 0;
        e.led    = led_m;
        e.halt   = halt_m;
        e.ifault = ifault_m;
        e.txd0   = after_rst_m;
        exp_q.push_back(e);
        @(posedge clk);
        model_edge(r, ioe, ia, doe, da, dd, we, rdy);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v, input logic [1:0] we, input logic rdy);
        op(0, 0, 16'h0, 0, a, v, we, rdy);
    endtask

    task automatic rd(input logic [15:0] a, input logic rdy);
        op(0, 0, 16'h0, 1, a, 16'h0, 2'b00, rdy);
    endtask

    task automatic idle(input logic rdy);
        op(0, 0, 16'h0, 0, 16'h0, 16'h0, 2'b00, rdy);
    endtask

    // Monitor: compares every presented output against the scoreboard.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] b;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("d_din", {16'h0, d_din}, {16'h0, e.d_exp});
            check("i_din", {16'h0, i_din}, {16'h0, e.i_exp});
            check("tx_valid", {31'h0, tx_valid}, {31'h0, e.txv});
            check("led", {16'h0, led}, {16'h0, e.led});
            check("halt", {31'h0, halt}, {31'h0, e.halt});
            check("i_fault", {31'h0, i_fault}, {31'h0, e.ifault});
            if (e.txd0) check("tx_data_after_reset", {24'h0, tx_data}, 32'h0);
        end
        if (!rst && tx_valid && tx_ready) begin
            if (tx_sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_unexpected_byte actual=%h required=none", tx_data);
            end else begin
                b = tx_sb.pop_front();
                check("tx_byte", {24'h0, tx_data}, {24'h0, b});
            end
        end
    end

    initial begin
        logic [15:0] pa, ia, v;
        int unsigned r;
        logic        ioe, rdy;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        op(1, 0, 16'h0, 0, 16'h0, 16'h0, 2'b00, 0);

        // Directed scenarios
        rd(16'h7f02, 0);                         // empty status 0x0001
        wr(16'h0100, 16'h1234, 2'b11, 0);
        rd(16'h0100, 0);                         // 0x1234
        wr(16'h0100, 16'hAB00, 2'b01, 0);
        rd(16'h0100, 0);                         // 0xAB34
        wr(16'h0100, 16'hFFFF, 2'b00, 0);        // no lanes: nothing written
        rd(16'h0101, 0);                         // odd address, same word
        wr(16'h7f00, 16'h00A5, 2'b10, 0);
        rd(16'h7f00, 0);                         // led 0x00A5
        rd(16'h0100, 0);                         // RAM unchanged
        for (int k = 0; k < 9; k++) wr(16'h7f02, 16'h0040 + 16'(k), 2'b11, 0);
        rd(16'h7f02, 0);                         // 0x0006
        wr(16'h7f02, 16'h0055, 2'b11, 1);        // full: push+pop together
        rd(16'h7f02, 0);                         // still full
        repeat (12) idle(1);
        rd(16'h7f02, 1);                         // empty with ovf: 0x0005
        wr(16'h7f04, 16'h0000, 2'b11, 0);        // clear counter
        repeat (100) idle(0);
        rd(16'h7f04, 0);
        rd(16'h7f06, 0);
        rd(16'h7f0e, 0);                         // unmapped / stats
        op(0, 1, 16'h7f10, 0, 16'h0, 16'h0, 2'b00, 0);
        op(0, 1, 16'h0100, 0, 16'h0, 16'h0, 2'b00, 0);
        wr(16'h7f08, 16'h0001, 2'b01, 0);
        idle(0);
        wr(16'h7f02, 16'h0077, 2'b10, 0);        // queue a byte, then reset drops it
        op(1, 0, 16'h0, 0, 16'h0, 16'h0, 2'b00, 1);
        idle(1);
        rd(16'h7f02, 1);

        // Randomized phase
        for (int k = 0; k < 16; k++) wr(16'h0200 + 16'(2 * k), 16'($urandom), 2'b11, 1);
        for (int n = 0; n < 3000; n++) begin
            r   = $urandom_range(0, 99);
            pa  = 16'h0200 + 16'($urandom_range(0, 31));
            v   = 16'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            ioe = $urandom_range(0, 1) == 1;
            ia  = ($urandom_range(0, 49) == 0) ? {8'h7f, 8'($urandom)}
                                               : 16'h0200 + 16'($urandom_range(0, 31));
            if (r < 1)       op(1, ioe, ia, 0, 16'h0, 16'h0, 2'b00, rdy);
            else if (r < 25) op(0, ioe, ia, 0, pa, v, 2'($urandom), rdy);
            else if (r < 45) op(0, ioe, ia, 1, pa, 16'h0, 2'b00, rdy);
            else if (r < 57) op(0, ioe, ia, 0, 16'h7f02, v, 2'($urandom_range(1, 3)), rdy);
            else if (r < 63) op(0, ioe, ia, 1, 16'h7f02 | 16'($urandom_range(0, 1)), 16'h0, 2'b00, rdy);
            else if (r < 70) op(0, ioe, ia, 1, 16'h7f04 + 16'(2 * $urandom_range(0, 1)), 16'h0, 2'b00, rdy);
            else if (r < 72) op(0, ioe, ia, 0, 16'h7f04, v, 2'($urandom_range(1, 3)), rdy);
            else if (r < 77) op(0, ioe, ia, 0, 16'h7f00, v, 2'($urandom), rdy);
            else if (r < 80) op(0, ioe, ia, 1, 16'h7f00, 16'h0, 2'b00, rdy);
            else if (r < 81) op(0, ioe, ia, 0, 16'h7f08, v, 2'($urandom_range(1, 3)), rdy);
            else if (r < 85) op(0, ioe, ia, 1, 16'h7f0a + 16'(2 * $urandom_range(0, 2)), 16'h0, 2'b00, rdy);
            else if (r < 86) op(0, ioe, ia, 0, 16'h7f0a, v, 2'b11, rdy);
            else if (r < 89) op(0, ioe, ia, $urandom_range(0, 1) == 1,
                                {8'h7f, 8'($urandom_range(16, 255))}, v, 2'($urandom), rdy);
            else             op(0, ioe, ia, 0, 16'h0, 16'h0, 2'b00, rdy);
        end

        repeat (2 * DEPTH + 4) idle(1);
        @(negedge clk);
        #1;
        check("tx_drained", tx_sb.size(), 32'd0);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
